// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator. It converts a command/response
// handshake into one AXI read or write and aborts on a per-transaction timeout.
module axi_lite_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 30,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              Local_Reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned AW     = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW     = C_M_AXI_DATA_WIDTH;
    localparam int unsigned SW     = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       RESP_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDATA,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              aw_done, w_done, active;

    // State and registered outputs; reset drops every valid/ready at once
    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
        end
    end

    // Next state and next registered outputs; timeout overrides any non-final step
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        aw_done       = !awvalid_q || M_AXI_AWREADY;
        w_done        = !wvalid_q || M_AXI_WREADY;
        active        = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                        (state_q == S_READ)  || (state_q == S_RDATA);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    awaddr_d      = cmd_addr;
                    araddr_d      = cmd_addr;
                    wdata_d       = cmd_wdata;
                    wstrb_d       = cmd_wstrb;
                    cnt_d         = '0;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = '0;
                    rsp_timeout_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_inc;
                if (aw_done && w_done) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end else begin
                    awvalid_d = !aw_done;
                    wvalid_d  = !w_done;
                end
            end
            S_WRESP: begin
                cnt_d = cnt_inc;
                if (M_AXI_BVALID) begin
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    bready_d = 1'b1;
                end
            end
            S_READ: begin
                cnt_d = cnt_inc;
                if (M_AXI_ARREADY && M_AXI_RVALID) begin
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (M_AXI_ARREADY) begin
                    rready_d = 1'b1;
                    state_d  = S_RDATA;
                end else begin
                    arvalid_d = 1'b1;
                    rready_d  = 1'b1;
                end
            end
            S_RDATA: begin
                cnt_d = cnt_inc;
                if (M_AXI_RVALID) begin
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    rready_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (active && (cnt_inc >= TIMEOUT_LIM) && (state_d != S_RESP)) begin
            state_d       = S_RESP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_TIMEOUT;
            rsp_timeout_d = 1'b1;
        end

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI4-Lite responder plus a response scoreboard.
module tb_axi_lite_master;

    logic        clk;
    logic        Local_Reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [29:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [29:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    axi_lite_master #(
        .C_M_AXI_ADDR_WIDTH (30),
        .C_M_AXI_DATA_WIDTH (32),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .S_AXI_ACLK    (clk),
        .Local_Reset   (Local_Reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard of expected responses
    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Responder controls and observation counters
    int   aw_delay = 0, w_delay = 0;
    bit   ar_never = 0, early_r = 0, b_never = 0;
    int   aw_wait, w_wait, awv_cycles, wv_cycles, arv_cycles, b_count, aw_viol, w_viol;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got;
    logic [29:0] aw_addr_s, ar_addr_s;
    logic [31:0] w_data_s;
    logic [3:0]  w_strb_s;
    logic [31:0] mem [0:255];

    // Responder: reacts at negedge to what the DUT presented and what completed at the last posedge
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        aw_wait = 0; w_wait = 0; awv_cycles = 0; wv_cycles = 0; arv_cycles = 0;
        b_count = 0; aw_viol = 0; w_viol = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; aw_got = 0; w_got = 0;
        aw_addr_s = 0; ar_addr_s = 0; w_data_s = 0; w_strb_s = 0;
        forever begin
            @(negedge clk);
            if (Local_Reset) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
            end else begin
                if (aw_hs && M_AXI_AWVALID) aw_viol++;
                if (w_hs && M_AXI_WVALID) w_viol++;
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (b_hs) begin M_AXI_BVALID = 0; b_count++; end
                if (aw_got && w_got && !M_AXI_BVALID && !b_never) begin
                    if (aw_addr_s < 30'h1000) begin
                        for (int b = 0; b < 4; b++)
                            if (w_strb_s[b]) mem[aw_addr_s[9:2]][8*b +: 8] = w_data_s[8*b +: 8];
                        M_AXI_BRESP = 2'b00;
                    end else begin
                        M_AXI_BRESP = 2'b11;
                    end
                    M_AXI_BVALID = 1; aw_got = 0; w_got = 0;
                end
                if (r_hs) M_AXI_RVALID = 0;
                if (ar_hs && !early_r) begin
                    M_AXI_RVALID = 1;
                    if (ar_addr_s < 30'h1000) begin
                        M_AXI_RDATA = mem[ar_addr_s[9:2]]; M_AXI_RRESP = 2'b00;
                    end else begin
                        M_AXI_RDATA = 0; M_AXI_RRESP = 2'b11;
                    end
                end
                M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_delay);
                aw_wait = (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_wait + 1 : 0;
                M_AXI_WREADY = M_AXI_WVALID && (w_wait >= w_delay);
                w_wait = (M_AXI_WVALID && !M_AXI_WREADY) ? w_wait + 1 : 0;
                M_AXI_ARREADY = M_AXI_ARVALID && !ar_never;
                if (early_r && M_AXI_ARVALID && !M_AXI_RVALID) begin
                    M_AXI_RVALID = 1; M_AXI_RDATA = 32'hDEAD_BEEF; M_AXI_RRESP = 2'b00;
                end
                aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
                if (aw_hs) aw_addr_s = M_AXI_AWADDR;
                w_hs = M_AXI_WVALID && M_AXI_WREADY;
                if (w_hs) begin w_data_s = M_AXI_WDATA; w_strb_s = M_AXI_WSTRB; end
                b_hs  = M_AXI_BVALID && M_AXI_BREADY;
                ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
                if (ar_hs) ar_addr_s = M_AXI_ARADDR;
                r_hs  = M_AXI_RVALID && M_AXI_RREADY;
                if (M_AXI_AWVALID) awv_cycles++;
                if (M_AXI_WVALID) wv_cycles++;
                if (M_AXI_ARVALID) arv_cycles++;
            end
        end
    end

    // Issue one command, push its expected response, then collect and score the response
    task automatic run_cmd(input string tag, input logic wr, input logic [29:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                           input logic exp_to, input int exp_lat, input int hold);
        exp_t        e;
        int          n, lat, stable;
        logic [36:0] snap;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
        check({tag, "/accept"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
        e.rdata = exp_rdata; e.resp = exp_resp; e.to = exp_to;
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 0;
        check({tag, "/busy"}, 32'({cmd_ready, busy}), 32'b01);
        lat = 1;
        while (!rsp_valid && lat < 64) begin @(negedge clk); lat++; end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        if (rsp_valid) begin
            stable = 0;
            snap = {rsp_rdata, rsp_resp, rsp_timeout, rsp_valid, cmd_ready};
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if ({rsp_rdata, rsp_resp, rsp_timeout, rsp_valid, cmd_ready} === snap && !cmd_ready)
                    stable++;
            end
            if (hold > 0) check({tag, "/hold_stable"}, 32'(stable), 32'(hold));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({tag, "/rdata"}, rsp_rdata, e.rdata);
                check({tag, "/resp"}, 32'(rsp_resp), 32'(e.resp));
                check({tag, "/timeout"}, 32'(rsp_timeout), 32'(e.to));
            end else begin
                n_checks++;
                $display("FAIL %s/scoreboard: got response expected none", tag);
            end
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            check({tag, "/idle_resume"}, 32'({rsp_valid, cmd_ready, busy}), 32'b010);
        end else begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
        end
    endtask

    int n, c_aw, c_w, c_ar, c_b;

    initial begin
        Local_Reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({cmd_ready, rsp_valid, busy, M_AXI_AWVALID, M_AXI_WVALID,
                                  M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_timeout, rsp_resp}), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        #1 Local_Reset = 0;
        check("rst_release_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        run_cmd("wr_0c",     1, 30'h0C,   32'h0000_0010, 4'hF, 32'h0, 2'b00, 0, 3, 0);
        run_cmd("rd_0c",     0, 30'h0C,   32'h0,         4'h0, 32'h0000_0010, 2'b00, 0, 3, 0);
        run_cmd("wr_strb",   1, 30'h0C,   32'hAABB_CCDD, 4'h5, 32'h0, 2'b00, 0, 3, 0);
        run_cmd("rd_strb",   0, 30'h0C,   32'h0,         4'h0, 32'h00BB_00DD, 2'b00, 0, 3, 0);
        run_cmd("wr_decerr", 1, 30'h2000, 32'h55,        4'hF, 32'h0, 2'b11, 0, 3, 0);
        run_cmd("rd_decerr", 0, 30'h2000, 32'h0,         4'h0, 32'h0, 2'b11, 0, 3, 0);

        aw_delay = 3;
        c_aw = awv_cycles; c_w = wv_cycles; c_b = b_count;
        run_cmd("wr_skew", 1, 30'h10, 32'h1234_5678, 4'hF, 32'h0, 2'b00, 0, 6, 0);
        aw_delay = 0;
        check("skew_awvalid_cycles", 32'(awv_cycles - c_aw), 32'd4);
        check("skew_wvalid_cycles",  32'(wv_cycles - c_w),   32'd1);
        check("skew_b_count",        32'(b_count - c_b),     32'd1);
        check("valid_after_handshake", 32'(aw_viol + w_viol), 32'd0);
        run_cmd("rd_skew", 0, 30'h10, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 0, 3, 0);

        early_r = 1;
        run_cmd("rd_early", 0, 30'h14, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 0, 2, 0);
        early_r = 0;

        ar_never = 1;
        c_ar = arv_cycles;
        run_cmd("rd_timeout", 0, 30'h0C, 32'h0, 4'h0, 32'h0, 2'b10, 1, 17, 0);
        ar_never = 0;
        check("timeout_arvalid_cycles", 32'(arv_cycles - c_ar), 32'd16);
        run_cmd("rd_after_to", 0, 30'h0C, 32'h0, 4'h0, 32'h00BB_00DD, 2'b00, 0, 3, 0);

        run_cmd("wr_bp", 1, 30'h18, 32'hCAFE_0001, 4'hF, 32'h0, 2'b00, 0, 3, 20);
        run_cmd("rd_bp", 0, 30'h18, 32'h0, 4'h0, 32'hCAFE_0001, 2'b00, 0, 3, 0);

        // Reset while waiting for B
        b_never = 1;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
        cmd_valid = 1; cmd_write = 1; cmd_addr = 30'h1C; cmd_wdata = 32'h0BAD; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!M_AXI_BREADY && n < 40) begin @(negedge clk); n++; end
        check("rst_mid_in_wresp", 32'(M_AXI_BREADY), 32'd1);
        #2 Local_Reset = 1;
        #1 check("rst_mid_outputs", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                          M_AXI_RREADY, rsp_valid, busy, cmd_ready}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 Local_Reset = 0;
        b_never = 0;
        check("rst_mid_release", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("rst_mid_cmd_ready", 32'({cmd_ready, rsp_valid}), 32'b10);
        run_cmd("rd_post_rst", 0, 30'h18, 32'h0, 4'h0, 32'hCAFE_0001, 2'b00, 0, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
